// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment bank sharing one segment bus. Drives an external decoder
// (digit nibble + active-high blank) and the active-low digit anodes.
// New BCD values are double-buffered and commit only on a frame boundary;
// supports leading-zero blanking, whole-display blink and anode dead time.
//
// Handshake: load is a single-cycle strobe with no back-pressure. Every cycle
// it is high overwrites the pending buffer. load_ack pulses for exactly one
// cycle when a pending value moves into the display buffer, which is the
// same cycle digit first shows digit 0 of that value.
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int DEAD_CYC     = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [3:0]              digit,
  output logic                    seg_blank,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    load_ack
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [PW:0]   DEAD_V = (PW + 1)'(DEAD_CYC);

  // Scan / buffer state
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] disp_q, disp_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  // Registered outputs
  logic [3:0]            digit_q, digit_d;
  logic                  seg_blank_q, seg_blank_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  load_ack_q, load_ack_d;

  // Internal decode
  logic                  tick;
  logic                  frame_wrap;
  logic                  commit;
  logic                  dead;
  logic                  lz_hit;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] zero_hi;

  // Next-state for prescaler, scan index, buffers and blink counter
  always_comb begin
    tick       = (pcnt_q == P_LAST);
    frame_wrap = tick && (idx_q == I_LAST);
    commit     = frame_wrap && pend_vld_q;

    pcnt_d = tick ? '0 : pcnt_q + 1'b1;

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
    end

    // Commit uses the pending value from before this edge; a same-edge
    // load becomes the next pending value.
    disp_d     = commit ? pend_q : disp_q;
    pend_d     = load ? value : pend_q;
    pend_vld_d = load | (pend_vld_q & ~commit);
    load_ack_d = commit;

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_wrap) begin
      if (fcnt_q == F_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Output decode from next state so outputs line up with the slot they describe
  always_comb begin
    dead = ({1'b0, pcnt_d} < DEAD_V);

    // zero_hi[i]: nibbles i..NUM_DIGITS-1 of the display value are all zero
    zero_run = 1'b1;
    zero_hi  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (disp_d[4*i +: 4] == 4'd0);
      zero_hi[i] = zero_run;
    end

    digit_d = 4'd0;
    lz_hit  = 1'b0;
    an_n_d  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        digit_d = disp_d[4*i +: 4];
        lz_hit  = (i != 0) && zero_hi[i];
        an_n_d[i] = dead;
      end
    end

    seg_blank_d = (blank_lz & lz_hit) | (blink_en & ~phase_d) | dead;
  end

  // Scan and buffer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      fcnt_q     <= '0;
      phase_q    <= 1'b1;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q     <= 4'd0;
      seg_blank_q <= 1'b1;
      an_n_q      <= '1;
      load_ack_q  <= 1'b0;
    end else begin
      digit_q     <= digit_d;
      seg_blank_q <= seg_blank_d;
      an_n_q      <= an_n_d;
      load_ack_q  <= load_ack_d;
    end
  end

  assign digit     = digit_q;
  assign seg_blank = seg_blank_q;
  assign an_n      = an_n_q;
  assign load_ack  = load_ack_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl with NUM_DIGITS=4, CLK_DIV=4, DEAD_CYC=1,
// BLINK_FRAMES=2. A time-based model predicts every output from the cycle
// count since reset release; directed literals pin key points.
module tb_sseg_scan_ctrl;

  localparam int N     = 4;
  localparam int CD    = 4;
  localparam int DC    = 1;
  localparam int BF    = 2;
  localparam int FRAME = N * CD;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        blink_en;
  logic [3:0]  digit;
  logic        seg_blank;
  logic [3:0]  an_n;
  logic        load_ack;

  sseg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .CLK_DIV     (CD),
    .DEAD_CYC    (DC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .digit    (digit),
    .seg_blank(seg_blank),
    .an_n     (an_n),
    .load_ack (load_ack)
  );

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int ack_cnt = 0;
  int ack_base;

  // ---------------- behavioural model ----------------
  // Time t = cycles since reset release; slot = t/CD, digit = slot mod N,
  // frame = t/FRAME, visible blink half when (frame/BF) is even.
  int          m_t;
  logic [15:0] m_disp, m_pend;
  logic        m_pvld;
  logic [3:0]  e_digit, e_an;
  logic        e_blank, e_ack;
  int          t_n;
  logic        cm;
  logic [15:0] nd;

  function automatic int slot_of(input int t);
    return (t / CD) % N;
  endfunction

  function automatic logic [3:0] f_digit(input logic [15:0] d, input int t);
    logic [15:0] sh;
    sh = d >> (4 * slot_of(t));
    return sh[3:0];
  endfunction

  function automatic logic [3:0] f_an(input int t);
    if ((t % CD) < DC) return 4'hF;
    return ~(4'b0001 << slot_of(t));
  endfunction

  function automatic logic f_blank(input logic [15:0] d, input int t,
                                   input logic blz, input logic ben);
    logic dead_c, vis, lz;
    int   s;
    s      = slot_of(t);
    dead_c = (t % CD) < DC;
    vis    = (((t / FRAME) / BF) % 2) == 0;
    lz     = blz && (s > 0) && ((d >> (4 * s)) == 16'd0);
    return lz || (ben && !vis) || dead_c;
  endfunction

  assign t_n = m_t + 1;
  assign cm  = ((t_n % FRAME) == 0) && m_pvld;
  assign nd  = cm ? m_pend : m_disp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t     <= 0;
      m_disp  <= '0;
      m_pend  <= '0;
      m_pvld  <= 1'b0;
      e_digit <= 4'd0;
      e_an    <= 4'hF;
      e_blank <= 1'b1;
      e_ack   <= 1'b0;
    end else begin
      m_t     <= t_n;
      m_disp  <= nd;
      m_pend  <= load ? value : m_pend;
      m_pvld  <= load ? 1'b1 : (cm ? 1'b0 : m_pvld);
      e_ack   <= cm;
      e_digit <= f_digit(nd, t_n);
      e_an    <= f_an(t_n);
      e_blank <= f_blank(nd, t_n, blank_lz, blink_en);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One cycle: sample at the falling edge and compare against the model
  task automatic tick();
    @(negedge clk);
    if (!rst) cyc++;
    chk("cmp_an_n", 32'(an_n), 32'(e_an));
    chk("cmp_digit", 32'(digit), 32'(e_digit));
    chk("cmp_seg_blank", 32'(seg_blank), 32'(e_blank));
    chk("cmp_load_ack", 32'(load_ack), 32'(e_ack));
    if (load_ack) ack_cnt++;
  endtask

  task automatic run_to(input int c);
    for (int k = 0; k < 1000 && cyc < c; k++) tick();
  endtask

  // Driver: one-cycle load strobe presented for the next rising edge
  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    tick();
    load  = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    tick();
    tick();
    chk("rst_an_n", 32'(an_n), 32'h0000000F);
    chk("rst_seg_blank", 32'(seg_blank), 32'd1);
    chk("rst_load_ack", 32'(load_ack), 32'd0);
    chk("rst_digit", 32'(digit), 32'd0);
    rst = 1'b0;
    cyc = 0;

    // Scan pattern: dead cycle then anode, 16-cycle period
    run_to(1);  chk("scan_t1", 32'(an_n), 32'hE);
    run_to(3);  chk("scan_t3", 32'(an_n), 32'hE);
    run_to(4);  chk("scan_t4_dead", 32'(an_n), 32'hF);
    run_to(5);  chk("scan_t5", 32'(an_n), 32'hD);

    // Load 1234 during cycle 5, commit at the frame wrap into cycle 16
    do_load(16'h1234);
    run_to(15); chk("ack_not_early", 32'(load_ack), 32'd0);
    run_to(16); chk("ack_1234", 32'(load_ack), 32'd1);
    run_to(17); chk("period_an", 32'(an_n), 32'hE);
                chk("d0_1234", 32'(digit), 32'h4);
                chk("vis_1234", 32'(seg_blank), 32'd0);
                chk("ack_one_cycle", 32'(load_ack), 32'd0);
    run_to(21); chk("d1_1234", 32'(digit), 32'h3);
    run_to(25); chk("d2_1234", 32'(digit), 32'h2);
    run_to(29); chk("d3_1234", 32'(digit), 32'h1);

    // Overwrite within a frame, then a load on the commit edge
    run_to(33); ack_base = ack_cnt; do_load(16'h1111);
    run_to(36); do_load(16'h2222);
    run_to(47); do_load(16'h3333);
    chk("ack_2222", 32'(load_ack), 32'd1);
    chk("one_ack_overwrite", 32'(ack_cnt - ack_base), 32'd1);
    run_to(49); chk("d0_2222", 32'(digit), 32'h2);
    run_to(64); chk("ack_3333", 32'(load_ack), 32'd1);
    run_to(65); chk("d0_3333", 32'(digit), 32'h3);
    chk("two_acks", 32'(ack_cnt - ack_base), 32'd2);

    // Leading-zero blanking
    run_to(66); blank_lz = 1'b1; do_load(16'h0050);
    run_to(81); chk("lz50_s0", 32'(seg_blank), 32'd0);
    run_to(85); chk("lz50_s1", 32'(seg_blank), 32'd0);
                chk("lz50_d1", 32'(digit), 32'h5);
    run_to(89); chk("lz50_s2", 32'(seg_blank), 32'd1);
    run_to(93); chk("lz50_s3", 32'(seg_blank), 32'd1);
    do_load(16'h0000);
    run_to(97);  chk("lz0_s0", 32'(seg_blank), 32'd0);
    run_to(101); chk("lz0_s1", 32'(seg_blank), 32'd1);
    run_to(109); chk("lz0_s3", 32'(seg_blank), 32'd1);
    run_to(110); blank_lz = 1'b0;
    run_to(117); chk("nolz_s1", 32'(seg_blank), 32'd0);
    run_to(125); chk("nolz_s3", 32'(seg_blank), 32'd0);

    // Blink: frames 8,9 visible, 10,11 blanked, 12 visible again
    run_to(126); blink_en = 1'b1;
    run_to(129); chk("blink_vis", 32'(seg_blank), 32'd0);
    run_to(161); chk("blink_off_s0", 32'(seg_blank), 32'd1);
    run_to(165); chk("blink_off_s1", 32'(seg_blank), 32'd1);
                 chk("blink_scan_s1", 32'(an_n), 32'hD);
    run_to(189); chk("blink_scan_s3", 32'(an_n), 32'h7);
    run_to(193); chk("blink_back_on", 32'(seg_blank), 32'd0);
    run_to(198); blink_en = 1'b0;

    // Non-BCD pass-through, leading-zero rule stopped by the F nibble
    run_to(200); blank_lz = 1'b1; do_load(16'hF0A9);
    run_to(209); chk("nb_d0", 32'(digit), 32'h9);
    run_to(213); chk("nb_d1", 32'(digit), 32'hA);
                 chk("nb_s1_vis", 32'(seg_blank), 32'd0);
    run_to(217); chk("nb_d2", 32'(digit), 32'h0);
                 chk("nb_s2_vis", 32'(seg_blank), 32'd0);
    run_to(221); chk("nb_d3", 32'(digit), 32'hF);

    // Reset mid-slot with a pending load: immediate outputs, no ack later
    run_to(230); do_load(16'h7777);
    #2 rst = 1'b1;
    #1;
    chk("async_an_n", 32'(an_n), 32'hF);
    chk("async_seg_blank", 32'(seg_blank), 32'd1);
    chk("async_load_ack", 32'(load_ack), 32'd0);
    ack_base = ack_cnt;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    run_to(1);  chk("rerst_an", 32'(an_n), 32'hE);
    run_to(33); chk("rerst_digit", 32'(digit), 32'h0);
    run_to(40); chk("no_ack_after_rst", 32'(ack_cnt - ack_base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
